sdram_req_arbiter: RTL and testbench

- Shares the single-port byte SDRAM controller between NUM_REQ clients. Client 0 is the CPU; the others are DMA, tape, floppy and similar.
- Presents the controller's tape-style port: level rd/wr held until acknowledge, write ack as a pulse, read ack as a toggle.
- Client 0 has fixed top priority; all other clients are served round-robin.
- Only one memory access is outstanding at a time. A watchdog aborts accesses that are never acknowledged.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_req_arbiter_if.sv | 24 ++
 rtl/sdram_rr_pick.sv | 36 +++
 rtl/sdram_req_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } arb_state_e;

    localparam logic [7:0] ERR_DATA = 8'hFF;

    function automatic int tmo_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Tape-style port between the arbiter (master) and the SDRAM controller (slave).
interface sdram_req_arbiter_if #(
    parameter int unsigned AW = 23
) ();

    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_rd;
    logic          mem_wr;
    logic [7:0]    mem_dout;
    logic          mem_rd_ack;
    logic          mem_wr_ack;

    modport master (
        output mem_addr, mem_din, mem_rd, mem_wr,
        input  mem_dout, mem_rd_ack, mem_wr_ack
    );

    modport slave (
        input  mem_addr, mem_din, mem_rd, mem_wr,
        output mem_dout, mem_rd_ack, mem_wr_ack
    );

endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational grant picker: client 0 has fixed priority, clients 1..NUM_REQ-1
// are searched round-robin starting at rr_i.
module sdram_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = 2
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IW-1:0]      rr_i,
    output logic [IW-1:0]      grant_o,
    output logic               valid_o
);

    int unsigned idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        if (elig_i[0]) begin
            valid_o = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
                idx = 32'(rr_i) + k;
                // Wrap past the last client back to client 1, never to client 0.
                if (idx >= NUM_REQ) begin
                    idx = idx - (NUM_REQ - 1);
                end
                if (!valid_o && elig_i[idx[IW-1:0]]) begin
                    valid_o = 1'b1;
                    grant_o = idx[IW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Shares one byte-wide SDRAM controller port between NUM_REQ clients, one
// access outstanding at a time, with a watchdog on unacknowledged accesses.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AW      = 23,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    cl_req,
    input  logic [NUM_REQ-1:0]    cl_we,
    input  logic [NUM_REQ*AW-1:0] cl_addr,
    input  logic [NUM_REQ*8-1:0]  cl_din,
    output logic [NUM_REQ-1:0]    cl_ack,
    output logic [NUM_REQ-1:0]    cl_err,
    output logic [7:0]            cl_dout,
    sdram_req_arbiter_if.master   mem
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int          TW = tmo_width(int'(TIMEOUT));
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0] last_q, last_d;
    logic [IW-1:0]      g_q, g_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [7:0]         din_q, din_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [7:0]         mem_din_q, mem_din_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [7:0]         cl_dout_q, cl_dout_d;
    logic [NUM_REQ-1:0] cl_ack_q, cl_ack_d;
    logic [NUM_REQ-1:0] cl_err_q, cl_err_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               rd_tog_q, rd_tog_d;

    logic [NUM_REQ-1:0] elig;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic [AW-1:0]      pick_addr;
    logic [7:0]         pick_din;
    logic               acc_done;

    // The client served last is masked for exactly one IDLE cycle.
    assign elig      = cl_req & ~last_q;
    assign pick_addr = cl_addr[pick_idx*AW +: AW];
    assign pick_din  = cl_din[pick_idx*8 +: 8];
    assign acc_done  = we_q ? mem.mem_wr_ack : (mem.mem_rd_ack != rd_tog_q);

    sdram_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .elig_i  (elig),
        .rr_i    (rr_q),
        .grant_o (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        last_d     = last_q;
        g_d        = g_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        cl_dout_d  = cl_dout_q;
        cl_ack_d   = '0;
        cl_err_d   = '0;
        tmo_d      = tmo_q;
        err_d      = err_q;
        rd_tog_d   = rd_tog_q;

        unique case (state_q)
            StIdle: begin
                rd_tog_d = mem.mem_rd_ack;
                if (pick_valid) begin
                    g_d     = pick_idx;
                    we_d    = cl_we[pick_idx];
                    addr_d  = pick_addr;
                    din_d   = pick_din;
                    state_d = StIssue;
                end else begin
                    last_d = '0;
                end
            end
            StIssue: begin
                mem_addr_d = addr_q;
                mem_din_d  = din_q;
                mem_wr_d   = we_q;
                mem_rd_d   = !we_q;
                tmo_d      = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (acc_done) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (!we_q) begin
                        cl_dout_d = mem.mem_dout;
                    end
                    state_d = StDone;
                end else if (tmo_q == TMO_MAX) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (!we_q) begin
                        cl_dout_d = ERR_DATA;
                    end
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: begin
                cl_ack_d[g_q] = 1'b1;
                cl_err_d[g_q] = err_q;
                err_d         = 1'b0;
                if (g_q != '0) begin
                    rr_d = (g_q == LAST_IDX) ? IW'(1) : g_q + 1'b1;
                end
                last_d      = '0;
                last_d[g_q] = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_q       <= IW'(1);
            last_q     <= '0;
            g_q        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            cl_dout_q  <= ERR_DATA;
            cl_ack_q   <= '0;
            cl_err_q   <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            rd_tog_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            last_q     <= last_d;
            g_q        <= g_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            cl_dout_q  <= cl_dout_d;
            cl_ack_q   <= cl_ack_d;
            cl_err_q   <= cl_err_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            rd_tog_q   <= rd_tog_d;
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_din  = mem_din_q;
    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_wr   = mem_wr_q;
    assign cl_ack       = cl_ack_q;
    assign cl_err       = cl_err_q;
    assign cl_dout      = cl_dout_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench: vector table plus directed contention, timeout and reset
// sequences, with an ack-ordered scoreboard and a latency-programmable memory model.
module tb_sdram_req_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 23;

    typedef struct {
        int            client;
        bit            we;
        bit            err;
        logic [7:0]    dout;
        logic [AW-1:0] addr;
        logic [7:0]    din;
    } exp_t;

    typedef struct {
        int            client;
        bit            we;
        logic [AW-1:0] addr;
        logic [7:0]    din;
        logic [7:0]    rdata;
        int            lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NR-1:0]    cl_req;
    logic [NR-1:0]    cl_we;
    logic [NR*AW-1:0] cl_addr;
    logic [NR*8-1:0]  cl_din;
    logic [NR-1:0]    cl_ack;
    logic [NR-1:0]    cl_err;
    logic [7:0]       cl_dout;

    sdram_req_arbiter_if #(.AW(AW)) mif ();

    sdram_req_arbiter #(
        .NUM_REQ (NR),
        .AW      (AW),
        .TIMEOUT (64)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cl_req  (cl_req),
        .cl_we   (cl_we),
        .cl_addr (cl_addr),
        .cl_din  (cl_din),
        .cl_ack  (cl_ack),
        .cl_err  (cl_err),
        .cl_dout (cl_dout),
        .mem     (mif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int target[NR] = '{default: 0};
    int acked[NR] = '{default: 0};
    int rise_cyc[NR] = '{default: 0};
    int ack_total = 0;
    int ack_seen_cyc = 0;
    exp_t sb[$];
    logic [7:0] last_rd;

    // Memory model controls and observations
    int            m_lat = 0;
    bit            m_never = 1'b0;
    logic [7:0]    m_rdata = 8'h00;
    int            kick_req = 0;
    int            kick_done = 0;
    int            hi_cycles = 0;
    int            act_cyc = 0;
    int            ack_cyc = 0;
    logic [AW-1:0] cap_addr = '0;
    logic [7:0]    cap_din = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Clients hold cl_req until they have collected their target number of acks.
    initial begin
        cl_req = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acked[i] < target[i]) begin
                    if (!cl_req[i]) rise_cyc[i] = cyc;
                    cl_req[i] = 1'b1;
                end else begin
                    cl_req[i] = 1'b0;
                end
            end
        end
    end

    // Controller model: acks m_lat+1 cycles into an access unless m_never is set.
    initial begin
        bit in_acc;
        bit acked_m;
        int cnt;
        in_acc = 1'b0;
        acked_m = 1'b0;
        cnt = 0;
        mif.mem_rd_ack = 1'b0;
        mif.mem_wr_ack = 1'b0;
        mif.mem_dout = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mif.mem_wr_ack = 1'b0;
            if (mif.mem_rd || mif.mem_wr) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    cnt = 0;
                    acked_m = 1'b0;
                    act_cyc = cyc;
                    cap_addr = mif.mem_addr;
                    cap_din = mif.mem_din;
                end
                cnt++;
                if (!m_never && !acked_m && cnt == m_lat + 1) begin
                    acked_m = 1'b1;
                    ack_cyc = cyc;
                    if (mif.mem_wr) begin
                        mif.mem_wr_ack = 1'b1;
                    end else begin
                        mif.mem_dout = m_rdata;
                        mif.mem_rd_ack = ~mif.mem_rd_ack;
                    end
                end
            end else begin
                if (in_acc) begin
                    hi_cycles = cnt;
                    in_acc = 1'b0;
                end
                if (kick_done != kick_req) begin
                    kick_done = kick_req;
                    mif.mem_rd_ack = ~mif.mem_rd_ack;
                    mif.mem_wr_ack = 1'b1;
                end
            end
        end
    end

    // Scoreboard: every cl_ack pops the oldest expected completion.
    initial begin
        exp_t e;
        logic [NR-1:0] oh;
        forever begin
            @(negedge clk);
            if ((cl_err & ~cl_ack) != '0) begin
                checks++;
                failures++;
                $display("FAIL err_without_ack: cl_err=%b cl_ack=%b", cl_err, cl_ack);
            end
            if (mif.mem_rd && mif.mem_wr) begin
                checks++;
                failures++;
                $display("FAIL rd_wr_exclusive: mem_rd=1 mem_wr=1, required not both");
            end
            if (cl_ack != '0) begin
                ack_total++;
                ack_seen_cyc = cyc;
                for (int i = 0; i < NR; i++) begin
                    if (cl_ack[i]) acked[i]++;
                end
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: cl_ack=%b, required no ack", cl_ack);
                end else begin
                    e = sb.pop_front();
                    oh = '0;
                    oh[e.client] = 1'b1;
                    check("ack_onehot", 32'(cl_ack), 32'(oh));
                    check("ack_err", 32'(cl_err), e.err ? 32'(oh) : 32'd0);
                    check("ack_dout", 32'(cl_dout), 32'(e.dout));
                    check("mem_addr", 32'(cap_addr), 32'(e.addr));
                    if (e.we) check("mem_din", 32'(cap_din), 32'(e.din));
                end
            end
        end
    end

    task automatic set_client(input int c, input bit we, input logic [AW-1:0] a,
                              input logic [7:0] d);
        cl_we[c] = we;
        cl_addr[c*AW +: AW] = a;
        cl_din[c*8 +: 8] = d;
    endtask

    task automatic expect_acc(input int c, input bit we, input bit err,
                              input logic [7:0] rdata);
        exp_t e;
        if (!we) last_rd = err ? 8'hFF : rdata;
        e.client = c;
        e.we = we;
        e.err = err;
        e.dout = last_rd;
        e.addr = cl_addr[c*AW +: AW];
        e.din = cl_din[c*8 +: 8];
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, input int bound);
        bit done;
        done = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            #1;
            done = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (acked[i] < target[i]) done = 1'b0;
            end
            if (done) break;
        end
        check({name, "_completed"}, 32'(done), 32'd1);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        int   n;

        vecs[0] = '{2, 1'b1, 23'h001234, 8'h5A, 8'h00, 3};
        vecs[1] = '{1, 1'b0, 23'h007FFF, 8'h11, 8'hC3, 2};
        vecs[2] = '{0, 1'b0, 23'h000000, 8'h22, 8'h3C, 0};
        vecs[3] = '{3, 1'b1, 23'h7FFFFF, 8'hFF, 8'h00, 5};
        vecs[4] = '{0, 1'b1, 23'h000001, 8'h00, 8'h00, 1};
        vecs[5] = '{3, 1'b0, 23'h400000, 8'h33, 8'h00, 10};

        cl_we = '0;
        cl_addr = '0;
        cl_din = '0;
        last_rd = 8'hFF;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd", 32'(mif.mem_rd), 32'd0);
        check("rst_mem_wr", 32'(mif.mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
        check("rst_mem_din", 32'(mif.mem_din), 32'd0);
        check("rst_cl_dout", 32'(cl_dout), 32'hFF);
        check("rst_cl_ack", 32'(cl_ack), 32'd0);
        check("rst_cl_err", 32'(cl_err), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single-client accesses: latency, strobe width and data path.
        for (int v = 0; v < 6; v++) begin
            m_lat = vecs[v].lat;
            m_rdata = vecs[v].rdata;
            set_client(vecs[v].client, vecs[v].we, vecs[v].addr, vecs[v].din);
            expect_acc(vecs[v].client, vecs[v].we, 1'b0, vecs[v].rdata);
            target[vecs[v].client]++;
            wait_done("vec", 100);
            check("strobe_cycles", 32'(hi_cycles), 32'(vecs[v].lat + 1));
            check("req_to_strobe", 32'(act_cyc - rise_cyc[vecs[v].client]), 32'd2);
            check("memack_to_clack", 32'(ack_seen_cyc - ack_cyc), 32'd2);
            repeat (3) @(negedge clk);
        end

        // Clients 1..3 held: round-robin 1,2,3,1,2,3.
        m_lat = 1;
        for (int c = 1; c < NR; c++) set_client(c, 1'b1, AW'(32'h100 * c), 8'(8'h10 + c));
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c < NR; c++) expect_acc(c, 1'b1, 1'b0, 8'h00);
        end
        for (int c = 1; c < NR; c++) target[c] += 2;
        wait_done("rr_123", 300);
        repeat (3) @(negedge clk);

        // CPU plus clients 1..3 held: 0,1,0,2,0,3.
        set_client(0, 1'b1, 23'h000ABC, 8'hA0);
        for (int c = 1; c < NR; c++) begin
            expect_acc(0, 1'b1, 1'b0, 8'h00);
            expect_acc(c, 1'b1, 1'b0, 8'h00);
        end
        target[0] += 3;
        for (int c = 1; c < NR; c++) target[c] += 1;
        wait_done("cpu_mix", 300);
        repeat (3) @(negedge clk);

        // Watchdog: read never acknowledged, then a late toggle and write pulse.
        m_never = 1'b1;
        set_client(1, 1'b0, 23'h012345, 8'h00);
        expect_acc(1, 1'b0, 1'b1, 8'h00);
        target[1]++;
        wait_done("timeout", 200);
        check("timeout_strobe_cycles", 32'(hi_cycles), 32'd64);
        m_never = 1'b0;
        n = ack_total;
        kick_req++;
        repeat (10) @(negedge clk);
        check("late_ack_ignored", 32'(ack_total), 32'(n));

        // Move rr off 1, then abort an access with reset.
        m_lat = 0;
        set_client(2, 1'b1, 23'h000222, 8'h22);
        expect_acc(2, 1'b1, 1'b0, 8'h00);
        target[2]++;
        wait_done("pre_reset", 100);
        repeat (3) @(negedge clk);
        m_never = 1'b1;
        set_client(3, 1'b0, 23'h000333, 8'h00);
        target[3]++;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mif.mem_rd) break;
        end
        check("abort_rd_started", 32'(mif.mem_rd), 32'd1);
        repeat (4) @(negedge clk);
        n = ack_total;
        reset = 1'b1;
        target[3] = acked[3];
        @(negedge clk);
        check("reset_drops_rd", 32'(mif.mem_rd), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_never = 1'b0;
        last_rd = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset_no_ack", 32'(ack_total), 32'(n));

        // After reset rr is 1, so client 2 must win over client 3.
        set_client(2, 1'b1, 23'h000444, 8'h44);
        set_client(3, 1'b1, 23'h000555, 8'h55);
        expect_acc(2, 1'b1, 1'b0, 8'h00);
        expect_acc(3, 1'b1, 1'b0, 8'h00);
        target[2]++;
        target[3]++;
        wait_done("post_reset", 100);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
